// File: rtl/fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// fwd_scoreboard
//
// Tracks the destinations of in-flight instructions for the r200 pipeline
// family and drives the operand-forwarding and decode-interlock controls.
// The decode instruction's destination enters a shift register of DEPTH
// stage entries (stage 1 = EX ... stage DEPTH = WB). The block compares the
// decode source operands against those entries to produce forward selects, a
// decode stall and a saturating stall-cycle counter.
//
// Build option:
//   FWD_SCOREBOARD_FWD_EN  defined   -> full forwarding. A load still in a
//                                       stage before LOAD_STAGE forces a
//                                       load-use stall.
//                          undefined -> interlock only. The forward selects
//                                       are tied to 0, and decode stalls on
//                                       any in-flight writer of a source.
//
// Parameters:
//   DEPTH       number of post-decode stages tracked (2..8)
//   LOAD_STAGE  first stage whose result bus carries load data (1..DEPTH)
//   RW          register address width
//   SW          forward-select width, derived from DEPTH
//
// Ports:
//   clk           clock, all state on the rising edge
//   rst           asynchronous active-high reset
//   id_valid      decode holds a real instruction
//   id_rs1/rs2    decode source register addresses
//   id_rd         decode destination register address
//   id_regwr      decode instruction writes id_rd
//   id_isload     decode instruction is a load
//   hold          whole pipeline frozen, entries keep their values
//   flush         kill the decode instruction
//   stall         decode must not issue this cycle (combinational)
//   rs1_sel/rs2_sel 0 = register file, k = stage-k result bus (combinational)
//   stall_cycles  saturating count of cycles that stalled while not held
// ---------------------------------------------------------------------------
module fwd_scoreboard #(
    parameter  int DEPTH      = 3,
    parameter  int LOAD_STAGE = 2,
    parameter  int RW         = 5,
    localparam int SW         = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic [RW-1:0] id_rd,
    input  logic          id_regwr,
    input  logic          id_isload,
    input  logic          hold,
    input  logic          flush,
    output logic          stall,
    output logic [SW-1:0] rs1_sel,
    output logic [SW-1:0] rs2_sel,
    output logic [31:0]   stall_cycles
);

    // Stage entries. A write to x0, or a non-writing instruction, is stored
    // as an invalid entry, so only valid_q needs a reset.
    logic [DEPTH:1] valid_q, valid_d;
    logic [RW-1:0]  rd_q [1:DEPTH];
    logic [RW-1:0]  rd_d [1:DEPTH];
    logic [31:0]    cnt_q, cnt_d;

    logic [DEPTH:1] match1, match2;
    logic           hazard;
    logic           issue;

`ifdef FWD_SCOREBOARD_FWD_EN
    logic [DEPTH:1] isload_q, isload_d;
    logic [SW-1:0]  sel1_raw, sel2_raw;
`else
    // The interlock-only build does not use the load flag or LOAD_STAGE.
    logic unused_cfg;
    assign unused_cfg = id_isload ^ LOAD_STAGE[0];
`endif

    // ---- decode-stage compare: operand matches against every stage ----
    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            match1[k] = valid_q[k] && (rd_q[k] == id_rs1) && (id_rs1 != '0);
            match2[k] = valid_q[k] && (rd_q[k] == id_rs2) && (id_rs2 != '0);
        end
    end

`ifdef FWD_SCOREBOARD_FWD_EN
    // A load is a hazard only while it sits in a stage before its data
    // appears on a result bus.
    always_comb begin
        hazard = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if ((k < LOAD_STAGE) && isload_q[k] && (match1[k] || match2[k])) begin
                hazard = 1'b1;
            end
        end
    end

    // Scan from the oldest stage to the youngest so that the youngest
    // matching writer wins when several stages hold the same rd.
    always_comb begin
        sel1_raw = '0;
        sel2_raw = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (match1[k]) sel1_raw = SW'(k);
            if (match2[k]) sel2_raw = SW'(k);
        end
    end

    assign rs1_sel = (id_valid && !stall) ? sel1_raw : '0;
    assign rs2_sel = (id_valid && !stall) ? sel2_raw : '0;
`else
    // The register file has no write-through, so any in-flight writer of a
    // source operand blocks decode until it retires.
    assign hazard  = |(match1 | match2);
    assign rs1_sel = '0;
    assign rs2_sel = '0;
`endif

    assign stall = id_valid && !flush && hazard;
    assign issue = id_valid && !stall && !flush && id_regwr && (id_rd != '0);

    // ---- next-state: shift entries one stage unless the pipeline is held ----
    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
`ifdef FWD_SCOREBOARD_FWD_EN
        isload_d = isload_q;
`endif
        if (!hold) begin
            for (int k = DEPTH; k >= 2; k--) begin
                valid_d[k] = valid_q[k-1];
                rd_d[k]    = rd_q[k-1];
`ifdef FWD_SCOREBOARD_FWD_EN
                isload_d[k] = isload_q[k-1];
`endif
            end
            valid_d[1] = issue;
            rd_d[1]    = id_rd;
`ifdef FWD_SCOREBOARD_FWD_EN
            isload_d[1] = id_isload;
`endif
        end
    end

    // The counter saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (stall && !hold && (cnt_q != '1)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // ---- stage register boundary: control state with async reset ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---- stage register boundary: entry payload, qualified by valid_q ----
    always_ff @(posedge clk) begin
        rd_q <= rd_d;
`ifdef FWD_SCOREBOARD_FWD_EN
        isload_q <= isload_d;
`endif
    end

    assign stall_cycles = cnt_q;

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised in-flight destination tracker and forwarding/interlock controller for the r200 pipeline family. It generalises the fixed 3-stage EX/MEM/WB hazard logic to a configurable number of post-decode stages and a configurable load-result stage. It sits beside the decode stage, records each issued instruction's destination in a shift register of stage entries, and produces per-operand forward selects, a decode stall, and a stall-cycle counter.

## Interface

- DEPTH, 3: number of post-decode stages tracked (stage 1 = EX … stage DEPTH = WB); legal 2–8
- LOAD_STAGE, 2: first stage whose result bus carries load data; 1 ≤ LOAD_STAGE ≤ DEPTH
- RW, 5: register address width
- SW, $clog2(DEPTH+1): forward-select width (derived, not overridden)

- clk  in  1  clock; one clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  decode holds a real instruction
- id_rs1, id_rs2  in  RW  source addresses in decode
- id_rd  in  RW  destination address in decode
- id_regwr  in  1  decode instruction writes id_rd
- id_isload  in  1  decode instruction is a load
- hold  in  1  whole pipeline frozen (memory busy)
- flush  in  1  kill decode instruction (taken branch/jump)
- stall  out  1  decode must not issue this cycle
- rs1_sel, rs2_sel  out  SW  0 = register file, k = stage-k result bus
- stall_cycles  out  32  saturating count of stall cycles

## Operation

- State: per stage k∈1..DEPTH: valid, rd, isload. rd of x0 or regwr=0 stored as valid=0.
- Match(k, rs): valid[k] && rd[k]==rs && rs!=0.
- Forward select: smallest k with Match(k, rs) (youngest wins); 0 if none.
- Load-use stall: exists k < LOAD_STAGE with Match(k, rs) && isload[k], for rs1 or rs2.
- stall = id_valid && !flush && (load-use on either operand). With flush=1 stall=0.
- rs1_sel/rs2_sel forced to 0 when stall=1 or id_valid=0.
- Advance (hold=0): entry[k+1] ← entry[k] for k<DEPTH; entry[DEPTH] retires. entry[1] ← decode entry if id_valid && !stall && !flush && id_regwr && id_rd!=0, else bubble (valid=0).
- hold=1: all entries unchanged; stall/sel still computed combinationally.
- stall_cycles increments when stall=1 && hold=0; saturates at 32'hFFFF_FFFF.

## Timing

- stall, rs1_sel, rs2_sel: combinational from inputs and current entries, same cycle.
- Entry update and counter on rising clk; issued instruction visible as stage 1 the next cycle.
- Load at stage 1 with LOAD_STAGE=2 and dependent in decode: exactly one stall cycle, then sel=2.
- rst asserted: all valid cleared, stall_cycles=0 immediately, stall=0, sels=0 (independent of clk); mid-operation reset discards all in-flight entries.
- Simultaneous flush and hold: hold wins for state (no advance); stall=0.
- Simultaneous writers of same rd in several stages: lowest stage number selected.

## Configuration

- FWD_SCOREBOARD_FWD_EN defined: forwarding as above.
- Undefined: interlock-only. rs1_sel/rs2_sel tied to 0; stall = id_valid && !flush && Match(k, rs) for any k∈1..DEPTH on either operand (register file has no write-through). isload ignored. Counter and advance rules unchanged.

## Test plan

- FWD_EN, DEPTH=3: issue add x5; next cycle decode reads rs1=x5 -> stall=0, rs1_sel=1; one cycle later (decode reads x5 again) rs1_sel=2, then 3, then 0.
- FWD_EN: issue lw x6 (isload); next cycle decode rs2=x6 -> stall=1 one cycle, stall_cycles=1, then stall=0, rs2_sel=2.
- Writer rd=x0 then reader rs1=x0 -> no entry stored, rs1_sel=0, stall=0.
- x7 written in stages 1 and 2 (back-to-back), decode reads x7 -> rs1_sel=1; flush=1 with id_valid -> stage 1 bubble next cycle, sel=0 for that rd.
- hold=1 for 4 cycles with load-use pending -> entries frozen, stall=1, stall_cycles unchanged; async rst mid-hold -> stall=0, stall_cycles=0 before next edge.
- FWD_EN undefined: add x5 then dependent reader -> stall=1 for 3 cycles, then issue with rs1_sel=0, stall_cycles=3.
